// File: rtl/dmem_pkg.sv
// Shared types, constants and the address-error check for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef logic [3:0] cnt_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  // Misaligned byte address, or word index past the end of storage.
  function automatic logic is_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] widx;
    widx = {2'b00, addr[31:ADDR_LSB]};
    return (addr[ADDR_LSB-1:0] != '0) || (widx >= depth);
  endfunction
endpackage

// File: rtl/dmem_word_array.sv
// Word storage: byte-enabled synchronous write, combinational read, async clear.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_BYTES-1:0] wbe,
  input  logic [31:0]           wdata,
  input  logic [AW-1:0]         raddr,
  output logic [31:0]           rdata
);
  logic [WORD_BYTES-1:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < WORD_BYTES; b++)
        if (wbe[b]) mem[waddr][b] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target: accept, wait LATENCY cycles, commit/read, respond.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state, state_nxt;
  cnt_t        cnt;
  logic        cap_write;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        fin, err_now, mem_we;
  logic [31:0] mem_rdata;

  assign err_now = is_err(cap_addr, DEPTH_WORDS);
  assign mem_we  = fin && cap_write && !err_now;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          fin       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
        cnt       <= cnt_t'(LATENCY - 1);
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      // Read sees storage before this edge's write; stores never return data.
      if (fin) begin
        rsp_err   <= err_now;
        rsp_rdata <= (cap_write || err_now) ? '0 : mem_rdata;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  dmem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (cap_addr[ADDR_LSB +: AW]),
    .wbe   (cap_be),
    .wdata (cap_wdata),
    .raddr (cap_addr[ADDR_LSB +: AW]),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_err;
  logic [31:0] rsp_rdata;

  logic        q1_valid = 0, q1_ready, q1_write = 0;
  logic [31:0] q1_addr = 0, q1_wdata = 0;
  logic [3:0]  q1_be = 0;
  logic        q1_rsp_valid, q1_rsp_err;
  logic [31:0] q1_rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(q1_valid), .req_ready(q1_ready),
    .req_write(q1_write), .req_addr(q1_addr), .req_wdata(q1_wdata), .req_be(q1_be),
    .rsp_valid(q1_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(q1_rsp_rdata), .rsp_err(q1_rsp_err));

  typedef struct {logic [31:0] rdata; logic err; int acc;} exp_t;
  exp_t q[$];

  int vectors = 0, miscompares = 0, cyc = 0, pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Holds the request until accepted, then scrambles inputs to prove they are only sampled at acceptance.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] erd, input logic eerr);
    int n = 0;
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 1);
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    q.push_back('{erd, eerr, cyc});
    req_valid = 0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  logic        pv = 0, pr = 0, pe = 0;
  logic [31:0] pd = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pv = 0; pr = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(rsp_valid), 1);
        chk("hold_rdata", rsp_rdata, pd);
        chk("hold_err", 32'(rsp_err), 32'(pe));
        chk("hold_req_ready", 32'(req_ready), 0);
      end
      if (rsp_valid && !pv) begin
        chk("rsp_pending", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("latency", 32'(cyc - q[0].acc), 2);
      end
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rdata", rsp_rdata, e.rdata);
        chk("err", 32'(rsp_err), 32'(e.err));
      end
      pv = rsp_valid; pr = rsp_ready; pd = rsp_rdata; pe = rsp_err;
    end
  end

  // LATENCY=1 instance: responses are single-cycle pulses; 4 stores then 4 loads of words 0..3.
  logic p1v = 0;
  always @(negedge clk) begin
    if (!rst) p1v = 0;
    else begin
      if (q1_rsp_valid) begin
        chk("l1_pulse_width", 32'(p1v), 0);
        chk("l1_err", 32'(q1_rsp_err), 0);
        chk("l1_rdata", q1_rsp_rdata, (pulses < 4) ? 32'h0 : 32'hA0 + 32'(pulses - 4));
        pulses++;
      end
      p1v = q1_rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int prev_acc, n;
    repeat (3) @(posedge clk); #1;
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_err", 32'(rsp_err), 0);
    rst = 1;
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(req_ready), 1);

    issue(0, 32'h10, 0, 4'hF, 32'h0, 0);
    issue(1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    issue(0, 32'h8, 0, 4'h0, 32'hDEADBEEF, 0);
    issue(1, 32'h8, 32'h000000AA, 4'h1, 32'h0, 0);
    issue(0, 32'h8, 0, 4'hF, 32'hDEADBEAA, 0);
    issue(1, 32'h8, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
    issue(0, 32'h8, 0, 4'h0, 32'hDEADBEAA, 0);
    issue(1, 32'h8, 32'h12340000, 4'hC, 32'h0, 0);
    issue(0, 32'h8, 0, 4'h0, 32'h1234BEAA, 0);
    drain();

    // Backpressure: second request stays pending until the first response handshakes.
    rsp_ready = 0;
    issue(0, 32'h8, 0, 4'h0, 32'h1234BEAA, 0);
    fork
      issue(0, 32'h10, 0, 4'h0, 32'h0, 0);
      begin repeat (7) @(posedge clk); #1; rsp_ready = 1; end
    join
    drain();

    issue(0, 32'h6, 0, 4'hF, 32'h0, 1);
    issue(1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    issue(1, 32'h400, 32'h11111111, 4'hF, 32'h0, 1);
    issue(0, 32'h0, 0, 4'h0, 32'hCAFEF00D, 0);
    issue(1, 32'h1, 32'h22222222, 4'hF, 32'h0, 1);
    issue(0, 32'h0, 0, 4'h0, 32'hCAFEF00D, 0);
    issue(0, 32'h3FC, 0, 4'h0, 32'h0, 0);
    issue(0, 32'h3FD, 0, 4'h0, 32'h0, 1);
    drain();

    // Reset while the store waits: outputs snap to reset values and the store is lost.
    req_valid = 1; req_write = 1; req_addr = 32'h4; req_wdata = 32'h12345678; req_be = 4'hF;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 0;
    chk("midop_in_wait", 32'(req_ready), 0);
    rst = 0; #1;
    chk("midop_req_ready", 32'(req_ready), 1);
    chk("midop_rsp_valid", 32'(rsp_valid), 0);
    chk("midop_rdata", rsp_rdata, 0);
    chk("midop_err", 32'(rsp_err), 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    issue(0, 32'h4, 0, 4'hF, 32'h0, 0);
    issue(0, 32'h0, 0, 4'hF, 32'h0, 0);
    drain();

    // Acceptance, response and handshake edges plus one IDLE cycle: LATENCY+2 between acceptances.
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      q1_valid = 1;
      q1_write = (i < 4);
      q1_addr  = 32'((i % 4) * 4);
      q1_wdata = 32'hA0 + 32'(i);
      q1_be    = 4'hF;
      n = 0;
      @(negedge clk);
      while (!q1_ready && n < 100) begin @(negedge clk); n++; end
      chk("l1_accept", 32'(q1_ready), 1);
      @(posedge clk); #1;
      if (i > 0) chk("l1_accept_gap", 32'(cyc - prev_acc), 3);
      prev_acc = cyc;
    end
    q1_valid = 0;
    repeat (5) @(posedge clk); #1;
    chk("l1_pulse_count", 32'(pulses), 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
